// File: rtl/add_sub_seq_if.sv
// Request/result handshake bundle for the sliced adder/subtractor.
// master drives operands and res_ready; slave returns the flagged result.
interface add_sub_seq_if #(
  parameter int WIDTH = 32
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             sub;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;
  logic             Zero;

  modport master (
    output start_valid, A, B, Cin, sub, res_ready,
    input  start_ready, res_valid, Sum, Cout, Ovf, Zero
  );

  modport slave (
    input  start_valid, A, B, Cin, sub, res_ready,
    output start_ready, res_valid, Sum, Cout, Ovf, Zero
  );
endinterface

// File: rtl/add_sub_seq.sv
// Multi-cycle adder/subtractor: one CHUNK-wide slice per clock,
// LSB first, carry held in a register between slices.
module add_sub_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  add_sub_seq_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_chk
      $error("add_sub_seq: WIDTH must be >=2 and a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK:0]   s_sl;
  logic             c_msb;
  logic [WIDTH-1:0] acc_nx;
  logic             last;
  logic             accept;

  assign accept = (state == IDLE) && bus.start_valid;
  assign last   = (cnt == CW'(NCHUNK - 1));

  always_comb begin
    a_sl   = a_q[cnt*CHUNK +: CHUNK];
    b_sl   = b_q[cnt*CHUNK +: CHUNK];
    s_sl   = {1'b0, a_sl} + {1'b0, b_sl}
           + {{CHUNK{1'b0}}, carry};
    // carry into the slice MSB recovered from its sum bit
    c_msb  = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ s_sl[CHUNK-1];
    acc_nx = acc;
    acc_nx[cnt*CHUNK +: CHUNK] = s_sl[CHUNK-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    if (bus.res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b1;
    end else if (accept) begin
      cnt   <= '0;
      a_q   <= bus.A;
      b_q   <= bus.sub ? ~bus.B : bus.B;
      carry <= bus.sub ? 1'b1 : bus.Cin;
      acc   <= '0;
    end else if (state == RUN) begin
      acc   <= acc_nx;
      carry <= s_sl[CHUNK];
      cnt   <= cnt + CW'(1);
      if (last) begin
        sum_q  <= acc_nx;
        cout_q <= s_sl[CHUNK];
        ovf_q  <= c_msb ^ s_sl[CHUNK];
        zero_q <= (acc_nx == '0);
      end
    end
  end

  assign bus.start_ready = (state == IDLE);
  assign bus.res_valid   = (state == DONE);
  assign bus.Sum         = sum_q;
  assign bus.Cout        = cout_q;
  assign bus.Ovf         = ovf_q;
  assign bus.Zero        = zero_q;
endmodule

// File: tb/tb_add_sub_seq.sv
// Bench for add_sub_seq: CHUNK=8, 32 and 1 instances side by side,
// results checked against a queue of expected values.
module tb_add_sub_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic [7:0]  lat;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  logic [31:0] a, b;
  logic        cin, sb, rr;
  logic [2:0]  sv;
  logic [1:0]  sel;

  logic [2:0]  vr, vv, vc, vo, vz;
  logic [31:0] vs[3];

  add_sub_seq_if #(.WIDTH(32)) ifs[3] ();

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      add_sub_seq #(
        .WIDTH(32),
        .CHUNK((g == 0) ? 8 : (g == 1) ? 32 : 1)
      ) u (
        .clk(clk),
        .rst(rst),
        .bus(ifs[g])
      );
      assign ifs[g].A           = a;
      assign ifs[g].B           = b;
      assign ifs[g].Cin         = cin;
      assign ifs[g].sub         = sb;
      assign ifs[g].res_ready   = rr;
      assign ifs[g].start_valid = sv[g];
      assign vr[g] = ifs[g].start_ready;
      assign vv[g] = ifs[g].res_valid;
      assign vc[g] = ifs[g].Cout;
      assign vo[g] = ifs[g].Ovf;
      assign vz[g] = ifs[g].Zero;
      assign vs[g] = ifs[g].Sum;
    end
  endgenerate

  logic        o_ready, o_valid, o_cout, o_ovf, o_zero;
  logic [31:0] o_sum;

  always_comb begin
    o_ready = vr[sel];
    o_valid = vv[sel];
    o_cout  = vc[sel];
    o_ovf   = vo[sel];
    o_zero  = vz[sel];
    o_sum   = vs[sel];
  end

  function automatic exp_t model(
    input logic [31:0] x, input logic [31:0] y,
    input logic ci, input logic s, input logic [7:0] l
  );
    logic [32:0] t;
    exp_t e;
    if (s) t = {1'b0, x} - {1'b0, y};
    else   t = {1'b0, x} + {1'b0, y} + 33'(ci);
    e.sum  = t[31:0];
    e.cout = s ? ~t[32] : t[32];
    if (s) e.ovf = (x[31] != y[31]) && (e.sum[31] != x[31]);
    else   e.ovf = (x[31] == y[31]) && (e.sum[31] != x[31]);
    e.zero = (e.sum == 32'h0);
    e.lat  = l;
    return e;
  endfunction

  function automatic exp_t mk(
    input logic [31:0] s, input logic c, input logic o,
    input logic z, input logic [7:0] l
  );
    exp_t e;
    e.sum = s; e.cout = c; e.ovf = o; e.zero = z; e.lat = l;
    return e;
  endfunction

  task automatic issue(
    input logic [1:0] s, input logic [31:0] x, input logic [31:0] y,
    input logic ci, input logic su, input exp_t e
  );
    sel = s; a = x; b = y; cin = ci; sb = su;
    sv = 3'b000;
    sv[s] = 1'b1;
    sbq.push_back(e);
    #1;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_ready_idle sel=%0d got %b want 1", s, o_ready);
    end
    @(posedge clk);
    #1;
    sv = 3'b000;
    a = $urandom; b = $urandom;
    cin = 1'($urandom); sb = 1'($urandom);
  endtask

  task automatic collect(input bit handoff);
    exp_t e;
    int lat;
    bit done;
    lat = 0;
    done = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (o_valid === 1'b1) done = 1;
    end
    e = sbq.pop_front();
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout sel=%0d got no res_valid want lat %0d",
               sel, e.lat);
      return;
    end
    if (lat != int'(e.lat)) begin
      errors++;
      $display("FAIL latency sel=%0d got %0d want %0d", sel, lat, e.lat);
    end
    checks++;
    if (o_sum !== e.sum) begin
      errors++;
      $display("FAIL sum sel=%0d got %h want %h", sel, o_sum, e.sum);
    end
    checks++;
    if (o_cout !== e.cout) begin
      errors++;
      $display("FAIL cout sel=%0d got %b want %b", sel, o_cout, e.cout);
    end
    checks++;
    if (o_ovf !== e.ovf) begin
      errors++;
      $display("FAIL ovf sel=%0d got %b want %b", sel, o_ovf, e.ovf);
    end
    checks++;
    if (o_zero !== e.zero) begin
      errors++;
      $display("FAIL zero sel=%0d got %b want %b", sel, o_zero, e.zero);
    end
    if (handoff) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
        errors++;
        $display("FAIL handoff sel=%0d got v=%b r=%b want v=0 r=1",
                 sel, o_valid, o_ready);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; rr = 1'b1; sv = 3'b000;
    a = '0; b = '0; cin = 0; sb = 0; sel = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sel = 2'(i);
      #1;
      checks++;
      if ({o_ready, o_valid, o_cout, o_ovf, o_zero} !== 5'b10001 ||
          o_sum !== 32'h0) begin
        errors++;
        $display("FAIL reset sel=%0d got r%b v%b c%b o%b z%b s=%h want r1 v0 c0 o0 z1 s=0",
                 i, o_ready, o_valid, o_cout, o_ovf, o_zero, o_sum);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add;
    issue(0, 32'hFFFF_FFFF, 32'h1, 0, 0, mk(32'h0, 1, 0, 1, 4));
    collect(1);
    issue(0, 32'h7FFF_FFFF, 32'h1, 0, 0, mk(32'h8000_0000, 0, 1, 0, 4));
    collect(1);
    issue(0, 32'h1234_5678, 32'h0F0F_0F0F, 1, 0,
          mk(32'h2143_6588, 0, 0, 0, 4));
    collect(1);
  endtask

  task automatic test_sub;
    issue(0, 32'h5, 32'h7, 1, 1, mk(32'hFFFF_FFFE, 0, 0, 0, 4));
    collect(1);
    issue(0, 32'h8000_0000, 32'h1, 0, 1, mk(32'h7FFF_FFFF, 1, 1, 0, 4));
    collect(1);
  endtask

  task automatic test_backpressure;
    exp_t e;
    e = mk(32'h0000_0003, 0, 0, 0, 4);
    rr = 1'b0;
    issue(0, 32'h1, 32'h2, 0, 0, e);
    sv[0] = 1'b1;
    a = 32'hDEAD_BEEF;
    collect(0);
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_sum !== e.sum ||
          o_cout !== e.cout || o_zero !== e.zero) begin
        errors++;
        $display("FAIL hold got v=%b r=%b s=%h want v=1 r=0 s=%h",
                 o_valid, o_ready, o_sum, e.sum);
      end
    end
    sv = 3'b000;
    rr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_sum !== e.sum) begin
      errors++;
      $display("FAIL release got v=%b r=%b s=%h want v=0 r=1 s=%h",
               o_valid, o_ready, o_sum, e.sum);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL no_second_op got v=%b r=%b want v=0 r=1",
               o_valid, o_ready);
    end
  endtask

  task automatic test_mid_reset;
    exp_t e;
    issue(0, 32'h1234_5678, 32'h0F0F_0F0F, 0, 0,
          mk(32'h2143_6587, 0, 0, 0, 4));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    e = sbq.pop_back();
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_sum !== 32'h0 ||
        o_zero !== 1'b1 || o_cout !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got v=%b r=%b s=%h z=%b want v=0 r=1 s=0 z=1 (drop %h)",
               o_valid, o_ready, o_sum, o_zero, e.sum);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(0, 32'hA5A5_0000, 32'h0000_5A5A, 0, 0,
          mk(32'hA5A5_5A5A, 0, 0, 0, 4));
    collect(1);
  endtask

  task automatic test_chunk32;
    issue(1, 32'hFFFF_FFFF, 32'h1, 0, 0, mk(32'h0, 1, 0, 1, 1));
    collect(1);
  endtask

  task automatic test_chunk1;
    issue(2, 32'hFFFF_FFFF, 32'h1, 0, 0, mk(32'h0, 1, 0, 1, 32));
    collect(1);
  endtask

  task automatic test_random;
    logic [31:0] x, y;
    logic ci, su;
    logic [7:0] l;
    for (int s = 0; s < 3; s++) begin
      l = (s == 0) ? 8'd4 : (s == 1) ? 8'd1 : 8'd32;
      for (int n = 0; n < 1000; n++) begin
        x = $urandom;
        y = $urandom;
        ci = 1'($urandom);
        su = 1'($urandom);
        if (n % 16 == 0) y = su ? x : ~x;
        issue(2'(s), x, y, ci, su, model(x, y, ci, su, l));
        collect(1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_mid_reset();
    test_chunk32();
    test_chunk1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
